uart_tx_fifo: RTL

Synchronous transmit FIFO for the CoreUARTapb TX path when `TX_FIFO = 1`. It buffers bytes written from the APB register interface and presents them to the asynchronous transmitter through a registered data output. The transmitter drives an active-low read strobe and reads back `fifo_empty` and `fifo_full`. The block sits between the APB TX-data register write decode and the transmitter.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_tx_fifo_if.sv | 35 +++
 rtl/uart_fifo_ram.sv | 40 ++++
 rtl/uart_tx_fifo.sv | 105 ++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ---- uart_pkg : shared UART widths, defaults and sizing helper -- rev 1.0 ----
package uart_pkg;

  localparam int UART_DATA_W       = 8;
  localparam int TX_FIFO_DEPTH_DEF = 16;

  typedef logic [UART_DATA_W-1:0] uart_byte_t;

  // Ceiling log2 with a fixed loop bound so it elaborates as a constant function.
  function automatic int clog2(input int value);
    int res;
    res = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 << i) < value) res = i + 1;
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_fifo_if.sv
`default_nettype none
// ---- uart_tx_fifo_if : write/read strobes and status of the TX FIFO -- rev 1.0 ----
interface uart_tx_fifo_if
  import uart_pkg::*;
#(
  parameter int WIDTH = UART_DATA_W,
  parameter int DEPTH = TX_FIFO_DEPTH_DEF
);

  localparam int CW = clog2(DEPTH) + 1;

  logic             fifo_flush;
  logic             fifo_write_tx;
  logic [WIDTH-1:0] tx_din;
  logic             fifo_read_tx;
  logic [WIDTH-1:0] tx_dout_reg;
  logic             fifo_empty;
  logic             fifo_full;
  logic             fifo_afull;
  logic [CW-1:0]    fifo_count;
  logic             overflow;
  logic             underflow;

  modport master (
    output fifo_flush, fifo_write_tx, tx_din, fifo_read_tx,
    input  tx_dout_reg, fifo_empty, fifo_full, fifo_afull, fifo_count, overflow, underflow
  );

  modport slave (
    input  fifo_flush, fifo_write_tx, tx_din, fifo_read_tx,
    output tx_dout_reg, fifo_empty, fifo_full, fifo_afull, fifo_count, overflow, underflow
  );

endinterface
`default_nettype wire

// File: rtl/uart_fifo_ram.sv
`default_nettype none
// ---- uart_fifo_ram : simple dual-port RAM, sync write, registered read -- rev 1.0 ----
module uart_fifo_ram
  import uart_pkg::*;
#(
  parameter int WIDTH = UART_DATA_W,
  parameter int DEPTH = TX_FIFO_DEPTH_DEF,
  parameter int AW    = clog2(DEPTH)
) (
  input  wire logic             clk,
  input  wire logic             reset_n,
  input  wire logic             we_i,
  input  wire logic [AW-1:0]    waddr_i,
  input  wire logic [WIDTH-1:0] wdata_i,
  input  wire logic             re_i,
  input  wire logic [AW-1:0]    raddr_i,
  output logic      [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // Storage array carries no reset so it can map onto block RAM.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Read-before-write: a same-address read returns the old word.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ---- uart_tx_fifo : CoreUARTapb transmit FIFO with registered head data -- rev 1.0 ----
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH       = TX_FIFO_DEPTH_DEF,
  parameter int WIDTH       = UART_DATA_W,
  parameter int AFULL_LEVEL = 12
) (
  input wire logic clk,
  input wire logic reset_n,
  uart_tx_fifo_if.slave bus
);

  localparam int          AW       = clog2(DEPTH);
  localparam int          CW       = AW + 1;
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_CNT = CW'(AFULL_LEVEL);

  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          empty_q, full_q, afull_q;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;
  logic          rd_ok_d, wr_ok_d;
  logic [WIDTH-1:0] rdata_d;

  always_comb begin
    rd_ok_d = ~bus.fifo_read_tx & (count_q != '0) & ~bus.fifo_flush;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the write.
    wr_ok_d = ~bus.fifo_write_tx & ((count_q != FULL_CNT) | rd_ok_d) & ~bus.fifo_flush;

    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;

    if (bus.fifo_flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
      ovf_d   = 1'b0;
      unf_d   = 1'b0;
    end else begin
      if (wr_ok_d) wptr_d = wptr_q + 1'b1;
      if (rd_ok_d) rptr_d = rptr_q + 1'b1;
      case ({wr_ok_d, rd_ok_d})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
      if (~bus.fifo_write_tx & ~wr_ok_d) ovf_d = 1'b1;
      if (~bus.fifo_read_tx  & ~rd_ok_d) unf_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      afull_q <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      empty_q <= (count_d == '0);
      full_q  <= (count_d == FULL_CNT);
      afull_q <= (count_d >= AFULL_CNT);
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  uart_fifo_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .reset_n (reset_n),
    .we_i    (wr_ok_d),
    .waddr_i (wptr_q),
    .wdata_i (bus.tx_din),
    .re_i    (rd_ok_d),
    .raddr_i (rptr_q),
    .rdata_o (rdata_d)
  );

  assign bus.tx_dout_reg = rdata_d;
  assign bus.fifo_empty  = empty_q;
  assign bus.fifo_full   = full_q;
  assign bus.fifo_afull  = afull_q;
  assign bus.fifo_count  = count_q;
  assign bus.overflow    = ovf_q;
  assign bus.underflow   = unf_q;

endmodule
`default_nettype wire
